// File: rtl/dma_pkg.sv
// Shared definitions for the DMA request/acknowledge protocol blocks.
package dma_pkg;

  localparam int DMA_AW = 21;
  localparam int DMA_DW = 8;

  localparam int ACC_CYCLES_MIN = 1;
  localparam int ACC_CYCLES_MAX = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } dma_state_t;

endpackage

// File: rtl/dma_rr_arb.sv
// Two-way round-robin grant. With both requests active, the channel that
// was not granted last wins. The pointer register is owned by the parent.
module dma_rr_arb
  import dma_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot grant; contention resolved against the last-granted channel
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dma_mem_arbiter.sv
// Memory-side responder for the DMA request/acknowledge protocol. Two
// requesters share the SRAM round-robin; accesses only start in cycles the
// Z80 leaves the memory free, and a started access always runs to completion.
module dma_mem_arbiter
  import dma_pkg::*;
#(
  parameter int ACC_CYCLES = 2
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        rnw,
  input  logic [DMA_AW-1:0] addr0,
  input  logic [DMA_AW-1:0] addr1,
  input  logic [DMA_DW-1:0] wd0,
  input  logic [DMA_DW-1:0] wd1,
  output logic [1:0]        ack,
  output logic [1:0]        done,
  output logic [DMA_DW-1:0] rd,
  input  logic              cpu_busy,
  output logic [DMA_AW-1:0] mem_addr,
  output logic [DMA_DW-1:0] mem_wd,
  input  logic [DMA_DW-1:0] mem_rd,
  output logic              mem_oe,
  output logic              mem_we,
  output logic              busy
);

  // Out-of-range access lengths are clamped so the 3-bit counter stays valid
  localparam int ACC_EFF = (ACC_CYCLES < ACC_CYCLES_MIN) ? ACC_CYCLES_MIN :
                           (ACC_CYCLES > ACC_CYCLES_MAX) ? ACC_CYCLES_MAX :
                           ACC_CYCLES;
  localparam logic [2:0] CNT_LOAD = 3'(ACC_EFF - 1);

  dma_state_t  state;
  logic [2:0]  cnt;
  logic        last;
  logic        gch;
  logic        dir_rd;
  logic [1:0]  gnt;
  logic        start;
  logic        sel_rnw;

  dma_rr_arb u_arb (
    .req  (req),
    .last (last),
    .gnt  (gnt)
  );

  // Accept decision and Mealy ack; ack is held off during reset and in ACC
  always_comb begin
    start   = (state == ST_IDLE) && !cpu_busy && (|req);
    ack     = (start && rst_n) ? gnt : 2'b00;
    sel_rnw = gnt[1] ? rnw[1] : rnw[0];
  end

  assign busy = (state == ST_ACC);

  // Access FSM: latch the granted request, hold strobes, then complete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      last     <= 1'b1;
      gch      <= 1'b0;
      dir_rd   <= 1'b0;
      done     <= 2'b00;
      rd       <= '0;
      mem_addr <= '0;
      mem_wd   <= '0;
      mem_oe   <= 1'b0;
      mem_we   <= 1'b0;
    end else begin
      done <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mem_addr <= gnt[1] ? addr1 : addr0;
            mem_wd   <= gnt[1] ? wd1 : wd0;
            dir_rd   <= sel_rnw;
            mem_oe   <= sel_rnw;
            mem_we   <= !sel_rnw;
            cnt      <= CNT_LOAD;
            gch      <= gnt[1];
            last     <= gnt[1];
            state    <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (cnt == 3'd0) begin
            mem_oe <= 1'b0;
            mem_we <= 1'b0;
            if (dir_rd) begin
              rd <= mem_rd;
            end
            done  <= gch ? 2'b10 : 2'b01;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Directed bench for dma_mem_arbiter with ACC_CYCLES=2 and a simple SRAM
// model: address 21'h012345 reads 8'hA5, any other address reads its low
// byte XOR 8'h5A.
module tb_dma_mem_arbiter;
  import dma_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req;
  logic [1:0]        rnw;
  logic [DMA_AW-1:0] addr0;
  logic [DMA_AW-1:0] addr1;
  logic [DMA_DW-1:0] wd0;
  logic [DMA_DW-1:0] wd1;
  logic [1:0]        ack;
  logic [1:0]        done;
  logic [DMA_DW-1:0] rd;
  logic              cpu_busy;
  logic [DMA_AW-1:0] mem_addr;
  logic [DMA_DW-1:0] mem_wd;
  logic [DMA_DW-1:0] mem_rd;
  logic              mem_oe;
  logic              mem_we;
  logic              busy;

  int compCount;
  int errCount;

  dma_mem_arbiter #(.ACC_CYCLES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .rnw      (rnw),
    .addr0    (addr0),
    .addr1    (addr1),
    .wd0      (wd0),
    .wd1      (wd1),
    .ack      (ack),
    .done     (done),
    .rd       (rd),
    .cpu_busy (cpu_busy),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd),
    .mem_oe   (mem_oe),
    .mem_we   (mem_we),
    .busy     (busy)
  );

  // SRAM read-data model
  assign mem_rd = (mem_addr == 21'h012345) ? 8'hA5 : (mem_addr[7:0] ^ 8'h5A);

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs just after the rising edge, then settle to the falling edge
  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] rw,
                               input logic [DMA_AW-1:0] a0, input logic [DMA_AW-1:0] a1,
                               input logic [DMA_DW-1:0] w0, input logic [DMA_DW-1:0] w1,
                               input logic cb);
    @(posedge clk);
    #1;
    req      = r;
    rnw      = rw;
    addr0    = a0;
    addr1    = a1;
    wd0      = w0;
    wd1      = w1;
    cpu_busy = cb;
    @(negedge clk);
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compCount++;
    assert (observed === expected)
    else begin
      errCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Expected ack/done per cycle of the contention run (hand-derived)
  logic [1:0] contAck  [13] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01,
                                2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
  logic [1:0] contDone [13] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10,
                                2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
  logic [DMA_AW-1:0] b2bAddr [4] = '{21'h00FFFF, 21'h010000, 21'h010001, 21'h010002};
  logic [DMA_DW-1:0] b2bRd   [4] = '{8'hA5, 8'h5A, 8'h5B, 8'h58};

  // Directed test sequence
  initial begin
    logic [DMA_AW-1:0] curAddr;
    int k;
    compCount = 0;
    errCount  = 0;
    rst_n    = 1'b0;
    req      = 2'b11;
    rnw      = 2'b11;
    addr0    = '0;
    addr1    = '0;
    wd0      = '0;
    wd1      = '0;
    cpu_busy = 1'b0;

    // Reset values, with both requests high to show ack is held off
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ack", 32'(ack), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_rd", 32'(rd), 32'h00);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("rst_mem_wd", 32'(mem_wd), 32'h0);
    checkOutput("rst_mem_oe", 32'(mem_oe), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 2'b00;

    // Single read on channel 0
    applyStimulus(2'b01, 2'b11, 21'h012345, 21'h0, 8'h00, 8'h00, 1'b0);
    checkOutput("rd_ack", 32'(ack), 32'h1);
    checkOutput("rd_busy_T", 32'(busy), 32'h0);
    applyStimulus(2'b00, 2'b11, 21'h000000, 21'h0, 8'h00, 8'h00, 1'b0);
    checkOutput("rd_ack_T1", 32'(ack), 32'h0);
    checkOutput("rd_oe_T1", 32'(mem_oe), 32'h1);
    checkOutput("rd_we_T1", 32'(mem_we), 32'h0);
    checkOutput("rd_addr_T1", 32'(mem_addr), 32'h012345);
    checkOutput("rd_busy_T1", 32'(busy), 32'h1);
    applyStimulus(2'b00, 2'b11, 21'h000000, 21'h0, 8'h00, 8'h00, 1'b0);
    checkOutput("rd_oe_T2", 32'(mem_oe), 32'h1);
    checkOutput("rd_addr_T2", 32'(mem_addr), 32'h012345);
    checkOutput("rd_done_T2", 32'(done), 32'h0);
    applyStimulus(2'b00, 2'b11, 21'h000000, 21'h0, 8'h00, 8'h00, 1'b0);
    checkOutput("rd_done_T3", 32'(done), 32'h1);
    checkOutput("rd_data_T3", 32'(rd), 32'hA5);
    checkOutput("rd_oe_T3", 32'(mem_oe), 32'h0);
    checkOutput("rd_busy_T3", 32'(busy), 32'h0);

    // Single write on channel 1
    applyStimulus(2'b10, 2'b01, 21'h0, 21'h1FFFFF, 8'h00, 8'h3C, 1'b0);
    checkOutput("wr_ack", 32'(ack), 32'h2);
    applyStimulus(2'b00, 2'b01, 21'h0, 21'h000000, 8'h00, 8'hFF, 1'b0);
    checkOutput("wr_we_T1", 32'(mem_we), 32'h1);
    checkOutput("wr_oe_T1", 32'(mem_oe), 32'h0);
    checkOutput("wr_wd_T1", 32'(mem_wd), 32'h3C);
    checkOutput("wr_addr_T1", 32'(mem_addr), 32'h1FFFFF);
    applyStimulus(2'b00, 2'b01, 21'h0, 21'h000000, 8'h00, 8'hFF, 1'b0);
    checkOutput("wr_we_T2", 32'(mem_we), 32'h1);
    checkOutput("wr_done_T2", 32'(done), 32'h0);
    applyStimulus(2'b00, 2'b01, 21'h0, 21'h000000, 8'h00, 8'hFF, 1'b0);
    checkOutput("wr_done_T3", 32'(done), 32'h2);
    checkOutput("wr_rd_kept", 32'(rd), 32'hA5);
    checkOutput("wr_we_T3", 32'(mem_we), 32'h0);

    // Contention: both requests held, grants alternate 0,1,0,1
    for (int i = 0; i <= 12; i++) begin
      applyStimulus((i < 12) ? 2'b11 : 2'b00, 2'b11, 21'h000100, 21'h000233,
                    8'h00, 8'h00, 1'b0);
      checkOutput($sformatf("cont_ack[%0d]", i), 32'(ack), 32'(contAck[i]));
      checkOutput($sformatf("cont_done[%0d]", i), 32'(done), 32'(contDone[i]));
      if (contDone[i] == 2'b01) checkOutput($sformatf("cont_rd0[%0d]", i), 32'(rd), 32'h5A);
      if (contDone[i] == 2'b10) checkOutput($sformatf("cont_rd1[%0d]", i), 32'(rd), 32'h69);
    end

    // CPU steal: no ack while cpu_busy, ack in the first free cycle
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b01, 2'b11, 21'h000011, 21'h0, 8'h00, 8'h00, 1'b1);
      checkOutput($sformatf("steal_noack[%0d]", i), 32'(ack), 32'h0);
    end
    applyStimulus(2'b01, 2'b11, 21'h000011, 21'h0, 8'h00, 8'h00, 1'b0);
    checkOutput("steal_ack", 32'(ack), 32'h1);
    applyStimulus(2'b00, 2'b11, 21'h000011, 21'h0, 8'h00, 8'h00, 1'b1);
    checkOutput("steal_oe_T1", 32'(mem_oe), 32'h1);
    applyStimulus(2'b00, 2'b11, 21'h000011, 21'h0, 8'h00, 8'h00, 1'b1);
    checkOutput("steal_oe_T2", 32'(mem_oe), 32'h1);
    applyStimulus(2'b01, 2'b11, 21'h000011, 21'h0, 8'h00, 8'h00, 1'b1);
    checkOutput("steal_done_T3", 32'(done), 32'h1);
    checkOutput("steal_rd_T3", 32'(rd), 32'h4B);
    checkOutput("steal_noack_T3", 32'(ack), 32'h0);

    // Back-to-back reads, requester bumps addr0 after each ack
    curAddr = 21'h00FFFF;
    k = 0;
    for (int j = 0; j <= 12; j++) begin
      applyStimulus((j < 10) ? 2'b01 : 2'b00, 2'b11, curAddr, 21'h0, 8'h00, 8'h00, 1'b0);
      if (j % 3 == 0 && j <= 9) begin
        checkOutput($sformatf("b2b_ack[%0d]", j), 32'(ack), 32'h1);
        curAddr = curAddr + 21'd1;
      end
      if (j % 3 == 1) begin
        checkOutput($sformatf("b2b_addr[%0d]", j), 32'(mem_addr), 32'(b2bAddr[j / 3]));
      end
      if (j % 3 == 0 && j > 0) begin
        checkOutput($sformatf("b2b_done[%0d]", j), 32'(done), 32'h1);
        checkOutput($sformatf("b2b_rd[%0d]", j), 32'(rd), 32'(b2bRd[k]));
        k++;
      end
    end

    // Reset during the first ACC cycle of a read
    applyStimulus(2'b01, 2'b11, 21'h000077, 21'h0, 8'h00, 8'h00, 1'b0);
    checkOutput("rst_mid_ack", 32'(ack), 32'h1);
    applyStimulus(2'b00, 2'b11, 21'h000077, 21'h0, 8'h00, 8'h00, 1'b0);
    checkOutput("rst_mid_oe_before", 32'(mem_oe), 32'h1);
    #2;
    rst_n = 1'b0;
    req   = 2'b00;
    #1;
    checkOutput("rst_mid_oe_async", 32'(mem_oe), 32'h0);
    checkOutput("rst_mid_busy_async", 32'(busy), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid_no_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    applyStimulus(2'b00, 2'b11, 21'h0, 21'h0, 8'h00, 8'h00, 1'b0);
    checkOutput("rst_mid_done_after", 32'(done), 32'h0);
    checkOutput("rst_mid_idle", 32'(busy), 32'h0);
    applyStimulus(2'b11, 2'b11, 21'h000100, 21'h000233, 8'h00, 8'h00, 1'b0);
    checkOutput("rst_mid_first_gnt", 32'(ack), 32'h1);
    applyStimulus(2'b00, 2'b11, 21'h0, 21'h0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
